goldschmidt_ctrl: RTL and testbench
===================================

# goldschmidt_ctrl

Control sequencer for the 16-bit Goldschmidt divider datapath. It accepts a divide request (N, D, initial approximation IA) through a start/done handshake and latches the operands. It drives the datapath's `load_regN`, `load_regD`, `sel_ND_mux` and `sel_K_mux` through the fixed initial-plus-refinement schedule, then captures the datapath `result` into a held quotient register. It sits directly upstream of `datapath`: all datapath inputs come from this block, and the datapath result returns to it.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width in bits
- `ITERS`, 4, number of refinement pairs (K·D, K·N) after the initial pair; legal range 1..15

Ports:
- `clk`  in  1  system clock, rising-edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request pulse; sampled only in IDLE
- `n_in`  in  WIDTH  numerator, captured at the accepted start edge
- `d_in`  in  WIDTH  denominator, captured at the accepted start edge
- `ia_in`  in  WIDTH  initial reciprocal approximation, captured at the accepted start edge
- `result`  in  WIDTH  datapath result (combinational view of its N register)
- `N`  out  WIDTH  latched numerator to datapath
- `D`  out  WIDTH  latched denominator to datapath
- `IA`  out  WIDTH  latched approximation to datapath
- `load_regN`  out  1  datapath N-register load enable
- `load_regD`  out  1  datapath D-register load enable
- `sel_ND_mux`  out  2  datapath multiplicand select
- `sel_K_mux`  out  1  1 = IA, 0 = K feedback
- `busy`  out  1  high from INIT_D through CAPTURE
- `done`  out  1  one-cycle pulse; quotient valid
- `quotient`  out  WIDTH  captured result; held until the next done

## Operation
- FSM states: IDLE, INIT_D, INIT_N, ITER_D, ITER_N, CAPTURE. Iteration counter `iter_cnt` is wide enough for ITERS.
- Transitions:
  - IDLE → INIT_D on `start`=1. `N`/`D`/`IA` load `n_in`/`d_in`/`ia_in` on that edge.
  - INIT_D → INIT_N.
  - INIT_N → ITER_D. `iter_cnt` clears to 0.
  - ITER_D → ITER_N.
  - ITER_N → ITER_D if `iter_cnt` < ITERS−1, incrementing `iter_cnt`; otherwise ITER_N → CAPTURE.
  - CAPTURE → IDLE. On this edge `quotient` ← `result` and `done` ← 1.
- Control outputs are Moore-decoded from state as (load_regD, load_regN, sel_ND_mux, sel_K_mux):
  - INIT_D: (1, 0, 00, 1)
  - INIT_N: (0, 1, 01, 1)
  - ITER_D: (1, 0, 10, 0)
  - ITER_N: (0, 1, 11, 0)
  - IDLE and CAPTURE: (0, 0, 00, 1)
- `load_regN` and `load_regD` are never high together.
- `N`/`D`/`IA` are stable from the start edge until the next accepted start.
- `start` is ignored in every state other than IDLE, and changes on `n_in`/`d_in`/`ia_in` have no effect while busy.
- `done` is registered and high for exactly one cycle. The FSM is in IDLE during that cycle, so `start` in the done cycle is accepted (back-to-back).
- Reset, asserted at any time including mid-operation:
  - state → IDLE, `iter_cnt` → 0
  - `N`, `D`, `IA`, `quotient` → 0
  - `done` → 0, `busy` → 0
  - Control outputs take the IDLE decode immediately.
  - An aborted operation produces no `done`.

## Timing
- Counting the start-accept edge as E0, state during each cycle:
  - E0–E1: INIT_D
  - E1–E2: INIT_N
  - E2 to E(2+2·ITERS): alternating ITER_D / ITER_N
  - then one cycle of CAPTURE
- `done` and the new `quotient` appear after edge E(3+2·ITERS), i.e. 11 cycles after start for ITERS=4.
- Throughput: one divide per 2·ITERS+3 cycles back-to-back.
- `result` is sampled only at the CAPTURE→IDLE edge. The datapath must present the final N-register value combinationally during CAPTURE.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle → immediately `busy`=0, `done`=0, `quotient`=0x0000, `N`/`D`/`IA`=0, controls (0,0,00,1).
- Single divide, ITERS=4: `start` with `n_in`=0x85E5, `d_in`=0xFEEB, `ia_in`=0x8000.
  - Controls follow (1,0,00,1), (0,1,01,1), then (1,0,10,0)/(0,1,11,0) ×4, then (0,0,00,1).
  - Bench drives `result`=0xA7F5 in CAPTURE → `done` pulses 11 cycles after start; `quotient`=0xA7F5 and holds.
- Start while busy: pulse `start` with new operands at cycle 5 → ignored; `N` stays 0x85E5; `done` still at cycle 11.
- Back-to-back: `start` high in the `done` cycle with `n_in`=0x4000 → `N`=0x4000 next cycle, INIT_D entered, second `done` 11 cycles later; first `quotient` held until then.
- Reset mid-operation in ITER_D (cycle 4) → IDLE, no `done`. A subsequent start completes normally in 11 cycles.
- Parameter sweep ITERS=1 → exactly one ITER_D/ITER_N pair, `done` 5 cycles after start.

Source files
------------

// File: rtl/goldschmidt_ctrl_if.sv
// rtl/goldschmidt_ctrl_if.sv - request/response and datapath control bundle for goldschmidt_ctrl
interface goldschmidt_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] n_in;
   logic [WIDTH-1:0] d_in;
   logic [WIDTH-1:0] ia_in;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] N;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] IA;
   logic             load_regN;
   logic             load_regD;
   logic [1:0]       sel_ND_mux;
   logic             sel_K_mux;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;

   modport master (
      output start, n_in, d_in, ia_in, result,
      input  N, D, IA, load_regN, load_regD, sel_ND_mux, sel_K_mux, busy, done, quotient
   );

   modport slave (
      input  start, n_in, d_in, ia_in, result,
      output N, D, IA, load_regN, load_regD, sel_ND_mux, sel_K_mux, busy, done, quotient
   );
endinterface

// File: rtl/goldschmidt_ctrl.sv
// rtl/goldschmidt_ctrl.sv - Goldschmidt divider sequencer: latches operands, steps the datapath, captures the quotient
module goldschmidt_ctrl #(
   parameter int WIDTH = 16,
   parameter int ITERS = 4
) (
   input logic               clk,
   input logic               reset,
   goldschmidt_ctrl_if.slave bus
);
   localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT_D,
      S_INIT_N,
      S_ITER_D,
      S_ITER_N,
      S_CAPTURE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
   logic [WIDTH-1:0] n_q, n_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] ia_q, ia_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic             done_q, done_d;

   logic             load_regN_o, load_regD_o, sel_K_mux_o, busy_o;
   logic [1:0]       sel_ND_mux_o;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         iter_cnt_q <= '0;
         n_q        <= '0;
         d_q        <= '0;
         ia_q       <= '0;
         quot_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         iter_cnt_q <= iter_cnt_d;
         n_q        <= n_d;
         d_q        <= d_d;
         ia_q       <= ia_d;
         quot_q     <= quot_d;
         done_q     <= done_d;
      end
   end

   // Controls are pure Moore decode so reset forces the IDLE pattern without waiting for a clock.
   always_comb begin
      state_d      = state_q;
      iter_cnt_d   = iter_cnt_q;
      n_d          = n_q;
      d_d          = d_q;
      ia_d         = ia_q;
      quot_d       = quot_q;
      done_d       = 1'b0;
      load_regD_o  = 1'b0;
      load_regN_o  = 1'b0;
      sel_ND_mux_o = 2'b00;
      sel_K_mux_o  = 1'b1;
      busy_o       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_INIT_D;
               n_d     = bus.n_in;
               d_d     = bus.d_in;
               ia_d    = bus.ia_in;
            end
         end
         S_INIT_D: begin
            load_regD_o = 1'b1;
            busy_o      = 1'b1;
            state_d     = S_INIT_N;
         end
         S_INIT_N: begin
            load_regN_o  = 1'b1;
            sel_ND_mux_o = 2'b01;
            busy_o       = 1'b1;
            iter_cnt_d   = '0;
            state_d      = S_ITER_D;
         end
         S_ITER_D: begin
            load_regD_o  = 1'b1;
            sel_ND_mux_o = 2'b10;
            sel_K_mux_o  = 1'b0;
            busy_o       = 1'b1;
            state_d      = S_ITER_N;
         end
         S_ITER_N: begin
            load_regN_o  = 1'b1;
            sel_ND_mux_o = 2'b11;
            sel_K_mux_o  = 1'b0;
            busy_o       = 1'b1;
            if (iter_cnt_q < LAST_ITER) begin
               iter_cnt_d = iter_cnt_q + CNT_W'(1);
               state_d    = S_ITER_D;
            end else begin
               state_d    = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            busy_o  = 1'b1;
            quot_d  = bus.result;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.N          = n_q;
   assign bus.D          = d_q;
   assign bus.IA         = ia_q;
   assign bus.quotient   = quot_q;
   assign bus.done       = done_q;
   assign bus.busy       = busy_o;
   assign bus.load_regN  = load_regN_o;
   assign bus.load_regD  = load_regD_o;
   assign bus.sel_ND_mux = sel_ND_mux_o;
   assign bus.sel_K_mux  = sel_K_mux_o;
endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// tb/tb_goldschmidt_ctrl.sv - self-checking bench for goldschmidt_ctrl against a schedule-timeline model
module tb_goldschmidt_ctrl;
   localparam int WIDTH = 16;
   localparam int ITERS = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   logic [WIDTH-1:0] exp_quot = '0;
   logic [WIDTH-1:0] exp_quot1 = '0;

   goldschmidt_ctrl_if #(.WIDTH(WIDTH)) bus ();
   goldschmidt_ctrl_if #(.WIDTH(WIDTH)) bus1 ();

   goldschmidt_ctrl #(.WIDTH(WIDTH), .ITERS(ITERS)) dut (.clk(clk), .reset(rst), .bus(bus));
   goldschmidt_ctrl #(.WIDTH(WIDTH), .ITERS(1)) dut1 (.clk(clk), .reset(rst), .bus(bus1));

   always #5 clk = ~clk;

   // Expected {load_regD, load_regN, sel_ND_mux, sel_K_mux} k cycles after the start-accept edge.
   function automatic logic [4:0] model_ctrl(input int k, input int iters);
      if (k == 0) return 5'b10001;
      if (k == 1) return 5'b01011;
      if (k >= 2 && k < 2 + 2 * iters) return ((k % 2) == 0) ? 5'b10100 : 5'b01110;
      return 5'b00001;
   endfunction

   task automatic run_divide(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d,
                             input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] res,
                             input int poke_k, input string tag);
      int last = 2 * ITERS + 3;
      logic [4:0] ctrl;
      bus.start  = 1'b1;
      bus.n_in   = n;
      bus.d_in   = d;
      bus.ia_in  = ia;
      bus.result = ~res;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.n_in  = WIDTH'($urandom);
      bus.d_in  = WIDTH'($urandom);
      bus.ia_in = WIDTH'($urandom);
      for (int k = 0; k <= last; k++) begin
         ctrl = {bus.load_regD, bus.load_regN, bus.sel_ND_mux, bus.sel_K_mux};
         checks++;
         if (ctrl !== model_ctrl(k, ITERS)) begin
            failures++;
            $display("FAIL %s ctrl k=%0d got=%b exp=%b", tag, k, ctrl, model_ctrl(k, ITERS));
         end
         checks++;
         if (bus.busy !== (k < last)) begin
            failures++;
            $display("FAIL %s busy k=%0d got=%b exp=%b", tag, k, bus.busy, (k < last));
         end
         checks++;
         if ({bus.N, bus.D, bus.IA} !== {n, d, ia}) begin
            failures++;
            $display("FAIL %s operands k=%0d got=%h/%h/%h exp=%h/%h/%h", tag, k, bus.N, bus.D, bus.IA, n, d, ia);
         end
         checks++;
         if (bus.done !== (k == last)) begin
            failures++;
            $display("FAIL %s done k=%0d got=%b exp=%b", tag, k, bus.done, (k == last));
         end
         checks++;
         if (bus.quotient !== ((k == last) ? res : exp_quot)) begin
            failures++;
            $display("FAIL %s quotient k=%0d got=%h exp=%h", tag, k, bus.quotient, (k == last) ? res : exp_quot);
         end
         bus.start = (k == poke_k);
         if (k == poke_k) begin
            bus.n_in  = WIDTH'($urandom);
            bus.d_in  = WIDTH'($urandom);
            bus.ia_in = WIDTH'($urandom);
         end
         bus.result = (k == last - 1) ? res : ~res;
         if (k < last) begin
            @(posedge clk); #1;
         end
      end
      exp_quot = res;
   endtask

   task automatic idle_check(input int cycles, input string tag);
      bus.start = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         bus.result = WIDTH'($urandom);
         @(posedge clk); #1;
         checks++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s idle i=%0d got done=%b busy=%b exp 0/0", tag, i, bus.done, bus.busy);
         end
         checks++;
         if (bus.quotient !== exp_quot) begin
            failures++;
            $display("FAIL %s held quotient i=%0d got=%h exp=%h", tag, i, bus.quotient, exp_quot);
         end
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.n_in = '0; bus.d_in = '0; bus.ia_in = '0; bus.result = '0;
      bus1.start = 1'b0; bus1.n_in = '0; bus1.d_in = '0; bus1.ia_in = '0; bus1.result = '0;
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus1.busy, bus1.done} !== 4'b0000) begin
         failures++;
         $display("FAIL reset busy/done got=%b exp=0000", {bus.busy, bus.done, bus1.busy, bus1.done});
      end
      checks++;
      if ({bus.N, bus.D, bus.IA, bus.quotient} !== '0) begin
         failures++;
         $display("FAIL reset regs got=%h/%h/%h/%h exp=0", bus.N, bus.D, bus.IA, bus.quotient);
      end
      checks++;
      if ({bus.load_regD, bus.load_regN, bus.sel_ND_mux, bus.sel_K_mux} !== 5'b00001) begin
         failures++;
         $display("FAIL reset ctrl got=%b exp=00001", {bus.load_regD, bus.load_regN, bus.sel_ND_mux, bus.sel_K_mux});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      exp_quot = '0;
      exp_quot1 = '0;
   endtask

   task automatic test_single();
      run_divide(16'h85E5, 16'hFEEB, 16'h8000, 16'hA7F5, -1, "single");
      idle_check(4, "single_hold");
   endtask

   task automatic test_start_while_busy();
      run_divide(16'h85E5, 16'hFEEB, 16'h8000, WIDTH'($urandom), 4, "busy_start");
   endtask

   task automatic test_back_to_back();
      run_divide(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), 16'h1234, -1, "b2b_first");
      run_divide(16'h4000, WIDTH'($urandom), WIDTH'($urandom), 16'h5678, -1, "b2b_second");
      run_divide(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), 16'h9ABC, -1, "b2b_third");
      idle_check(2, "b2b_hold");
   endtask

   task automatic test_reset_mid_op();
      logic [4:0] ctrl;
      bus.start = 1'b1;
      bus.n_in  = WIDTH'($urandom);
      bus.d_in  = WIDTH'($urandom);
      bus.ia_in = WIDTH'($urandom);
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      ctrl = {bus.load_regD, bus.load_regN, bus.sel_ND_mux, bus.sel_K_mux};
      checks++;
      if (ctrl !== model_ctrl(4, ITERS)) begin
         failures++;
         $display("FAIL abort pre-reset ctrl got=%b exp=%b", ctrl, model_ctrl(4, ITERS));
      end
      #2;
      rst = 1'b1;
      #1;
      ctrl = {bus.load_regD, bus.load_regN, bus.sel_ND_mux, bus.sel_K_mux};
      checks++;
      if (ctrl !== 5'b00001 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         failures++;
         $display("FAIL abort reset ctrl/busy/done got=%b/%b/%b exp=00001/0/0", ctrl, bus.busy, bus.done);
      end
      checks++;
      if ({bus.N, bus.D, bus.IA, bus.quotient} !== '0) begin
         failures++;
         $display("FAIL abort reset regs got=%h/%h/%h/%h exp=0", bus.N, bus.D, bus.IA, bus.quotient);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      exp_quot = '0;
      exp_quot1 = '0;
      idle_check(15, "abort_no_done");
      run_divide(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), -1, "after_abort");
      idle_check(1, "after_abort_hold");
   endtask

   task automatic test_random();
      int poke;
      for (int t = 0; t < 8; t++) begin
         poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2 * ITERS + 2)) : -1;
         run_divide(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), poke, "random");
         idle_check(int'($urandom_range(0, 2)), "random_gap");
      end
   endtask

   task automatic test_param_sweep();
      logic [WIDTH-1:0] n, d, ia, res;
      logic [4:0] ctrl;
      n = WIDTH'($urandom); d = WIDTH'($urandom); ia = WIDTH'($urandom); res = WIDTH'($urandom);
      bus1.start = 1'b1; bus1.n_in = n; bus1.d_in = d; bus1.ia_in = ia; bus1.result = ~res;
      @(posedge clk); #1;
      bus1.start = 1'b0;
      bus1.n_in = ~n;
      for (int k = 0; k <= 5; k++) begin
         ctrl = {bus1.load_regD, bus1.load_regN, bus1.sel_ND_mux, bus1.sel_K_mux};
         checks++;
         if (ctrl !== model_ctrl(k, 1)) begin
            failures++;
            $display("FAIL iters1 ctrl k=%0d got=%b exp=%b", k, ctrl, model_ctrl(k, 1));
         end
         checks++;
         if (bus1.done !== (k == 5) || bus1.busy !== (k < 5)) begin
            failures++;
            $display("FAIL iters1 done/busy k=%0d got=%b/%b exp=%b/%b", k, bus1.done, bus1.busy, (k == 5), (k < 5));
         end
         checks++;
         if (bus1.quotient !== ((k == 5) ? res : exp_quot1) || bus1.N !== n) begin
            failures++;
            $display("FAIL iters1 quotient/N k=%0d got=%h/%h exp=%h/%h", k, bus1.quotient, bus1.N, (k == 5) ? res : exp_quot1, n);
         end
         bus1.result = (k == 4) ? res : ~res;
         if (k < 5) begin
            @(posedge clk); #1;
         end
      end
      exp_quot1 = res;
   endtask

   initial begin
      test_reset();
      test_single();
      test_start_while_busy();
      idle_check(2, "post_busy_start");
      test_back_to_back();
      test_reset_mid_op();
      test_random();
      test_param_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
